// File: rtl/snapshot_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : snapshot_frame_tx_if
// Description : Byte stream valid/ready channel from the snapshot framer to
//               the debug UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface snapshot_frame_tx_if #(
  parameter int N_BITS = 8
);
  logic              tx_valid;
  logic              tx_ready;
  logic [N_BITS-1:0] tx_data;

  // Framer side: offers bytes, sees the transmitter's ready.
  modport master (output tx_valid, output tx_data, input tx_ready);
  // Transmitter side: accepts bytes.
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/snapshot_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : snapshot_frame_tx
// Description : Captures up to N_CH pipeline-stage buses on a start pulse and
//               streams them as a framed byte sequence (header, mask, selected
//               channels LSB-first, XOR checksum) over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module snapshot_frame_tx #(
  parameter int              N_CH   = 4,
  parameter int              NB_CH  = 40,
  parameter int              N_BITS = 8,
  parameter logic [N_BITS-1:0] HEADER = 8'hA5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [N_CH-1:0]         ch_mask_i,
  input  logic [N_CH*NB_CH-1:0]   snapshot_i,
  snapshot_frame_tx_if.master     tx,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int NB_BYTES_CH = (NB_CH + 7) / 8;
  localparam int PAD_W       = NB_BYTES_CH * 8;
  localparam int BYTE_W      = (NB_BYTES_CH > 1) ? $clog2(NB_BYTES_CH) : 1;
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NB_BYTES_CH - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HEADER   = 3'd1;
  localparam logic [2:0] S_MASK     = 3'd2;
  localparam logic [2:0] S_PAYLOAD  = 3'd3;
  localparam logic [2:0] S_CHECKSUM = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [N_CH*NB_CH-1:0] snap_q,  snap_d;
  logic [N_CH-1:0]       mask_q,  mask_d;
  logic [N_BITS-1:0]     csum_q,  csum_d;
  logic [CH_W-1:0]       ch_q,    ch_d;
  logic [BYTE_W-1:0]     byte_q,  byte_d;

  logic [NB_CH-1:0]      chan_sel;
  logic [PAD_W-1:0]      chan_pad;
  logic [N_BITS-1:0]     pay_byte;
  logic [N_BITS-1:0]     data;
  logic                  valid;
  logic                  xfer;
  logic                  first_found;
  logic                  next_found;
  logic [CH_W-1:0]       first_ch;
  logic [CH_W-1:0]       next_ch;

  assign valid  = (state_q == S_HEADER) || (state_q == S_MASK) ||
                  (state_q == S_PAYLOAD) || (state_q == S_CHECKSUM);
  assign xfer   = valid && tx.tx_ready;
  assign busy_o = valid;
  assign done_o = (state_q == S_DONE);

  assign tx.tx_valid = valid;
  assign tx.tx_data  = data;

  // Pick the current channel out of the latched snapshot and pad it to bytes.
  always_comb begin
    chan_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(ch_q) == k) chan_sel = snap_q[k*NB_CH +: NB_CH];
    end
    chan_pad = PAD_W'(chan_sel);
  end

  // Byte of the current channel selected by the byte index (LSB first).
  always_comb begin
    pay_byte = '0;
    for (int b = 0; b < NB_BYTES_CH; b++) begin
      if (int'(byte_q) == b) pay_byte = chan_pad[b*8 +: 8];
    end
  end

  // Priority search for the lowest enabled channel overall and above ch_q.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    next_found  = 1'b0;
    next_ch     = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (mask_q[k]) begin
        first_found = 1'b1;
        first_ch    = CH_W'(k);
        if (k > int'(ch_q)) begin
          next_found = 1'b1;
          next_ch    = CH_W'(k);
        end
      end
    end
  end

  // Output byte multiplexer by frame section.
  always_comb begin
    case (state_q)
      S_HEADER:   data = HEADER;
      S_MASK:     data = N_BITS'(mask_q);
      S_PAYLOAD:  data = pay_byte;
      S_CHECKSUM: data = csum_q;
      default:    data = '0;
    endcase
  end

  // Frame sequencing: capture on start, advance only on accepted bytes.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    mask_d  = mask_q;
    ch_d    = ch_q;
    byte_d  = byte_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_HEADER;
          snap_d  = snapshot_i;
          mask_d  = ch_mask_i;
          ch_d    = '0;
          byte_d  = '0;
        end
      end
      S_HEADER: begin
        if (xfer) state_d = S_MASK;
      end
      S_MASK: begin
        if (xfer) begin
          if (first_found) begin
            state_d = S_PAYLOAD;
            ch_d    = first_ch;
            byte_d  = '0;
          end else begin
            state_d = S_CHECKSUM;
          end
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          if (byte_q == LAST_BYTE) begin
            byte_d = '0;
            if (next_found) ch_d = next_ch;
            else            state_d = S_CHECKSUM;
          end else begin
            byte_d = byte_q + BYTE_W'(1);
          end
        end
      end
      S_CHECKSUM: begin
        if (xfer) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Running XOR of accepted bytes; stalls do not re-add the held byte.
  always_comb begin
    csum_d = csum_q;
    if ((state_q == S_IDLE) && start_i) csum_d = '0;
    else if (xfer)                     csum_d = csum_q ^ data;
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      mask_q  <= '0;
      csum_q  <= '0;
      ch_q    <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      mask_q  <= mask_d;
      csum_q  <= csum_d;
      ch_q    <= ch_d;
      byte_q  <= byte_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snapshot_frame_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_snapshot_frame_tx
// Description : Self-checking bench for snapshot_frame_tx: three instances
//               (4x40, 2x34 padding, 8x137 wide counters) checked every cycle
//               against a byte-list frame model plus literal frame vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snapshot_frame_tx;

  localparam int NCH_A = 4, NBCH_A = 40;
  localparam int NCH_B = 2, NBCH_B = 34;
  localparam int NCH_C = 8, NBCH_C = 137;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [2:0]               start;
  logic [2:0]               ready;
  logic [NCH_A-1:0]         mask_a;
  logic [NCH_B-1:0]         mask_b;
  logic [NCH_C-1:0]         mask_c;
  logic [NCH_A*NBCH_A-1:0]  snap_a;
  logic [NCH_B*NBCH_B-1:0]  snap_b;
  logic [NCH_C*NBCH_C-1:0]  snap_c;
  logic                     busy_a, busy_b, busy_c, done_a, done_b, done_c;

  snapshot_frame_tx_if #(.N_BITS(8)) if_a ();
  snapshot_frame_tx_if #(.N_BITS(8)) if_b ();
  snapshot_frame_tx_if #(.N_BITS(8)) if_c ();
  assign if_a.tx_ready = ready[0];
  assign if_b.tx_ready = ready[1];
  assign if_c.tx_ready = ready[2];

  snapshot_frame_tx #(.N_CH(NCH_A), .NB_CH(NBCH_A), .N_BITS(8), .HEADER(8'hA5)) u_a (
    .clock(clock), .reset(reset), .start_i(start[0]), .ch_mask_i(mask_a),
    .snapshot_i(snap_a), .tx(if_a.master), .busy_o(busy_a), .done_o(done_a));
  snapshot_frame_tx #(.N_CH(NCH_B), .NB_CH(NBCH_B), .N_BITS(8), .HEADER(8'hA5)) u_b (
    .clock(clock), .reset(reset), .start_i(start[1]), .ch_mask_i(mask_b),
    .snapshot_i(snap_b), .tx(if_b.master), .busy_o(busy_b), .done_o(done_b));
  snapshot_frame_tx #(.N_CH(NCH_C), .NB_CH(NBCH_C), .N_BITS(8), .HEADER(8'hA5)) u_c (
    .clock(clock), .reset(reset), .start_i(start[2]), .ch_mask_i(mask_c),
    .snapshot_i(snap_c), .tx(if_c.master), .busy_o(busy_c), .done_o(done_c));

  logic [2:0] valid_v, busy_v, done_v;
  logic [7:0] data_v [3];
  assign valid_v   = {if_c.tx_valid, if_b.tx_valid, if_a.tx_valid};
  assign busy_v    = {busy_c, busy_b, busy_a};
  assign done_v    = {done_c, done_b, done_a};
  assign data_v[0] = if_a.tx_data;
  assign data_v[1] = if_b.tx_data;
  assign data_v[2] = if_c.tx_data;

  // Model state (written only by the compare process)
  logic [7:0] exp_q [3][$];
  logic [7:0] got_q [3][$];
  logic [7:0] mdl_q [$];
  logic [2:0] exp_busy   = '0;
  logic [2:0] exp_done   = '0;
  logic [2:0] prev_stall = '0;
  logic [7:0] prev_data [3];
  // Literal expectations (written only by the stimulus process)
  logic [7:0] lit_q [$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Frame as a list of bytes built straight from the framing rules.
  task automatic build_frame(input int d);
    int nch, nbch, nbytes;
    logic [7:0]    m;
    logic [2047:0] s;
    logic [7:0]    by, cs;
    case (d)
      0:       begin nch = NCH_A; nbch = NBCH_A; m = 8'(mask_a); s = 2048'(snap_a); end
      1:       begin nch = NCH_B; nbch = NBCH_B; m = 8'(mask_b); s = 2048'(snap_b); end
      default: begin nch = NCH_C; nbch = NBCH_C; m = 8'(mask_c); s = 2048'(snap_c); end
    endcase
    nbytes = (nbch + 7) / 8;
    mdl_q.delete();
    mdl_q.push_back(8'hA5);
    mdl_q.push_back(m);
    for (int k = 0; k < nch; k++) begin
      if (m[k]) begin
        for (int b = 0; b < nbytes; b++) begin
          by = 8'h00;
          for (int i = 0; i < 8; i++)
            if (b*8 + i < nbch) by[i] = s[k*nbch + b*8 + i];
          mdl_q.push_back(by);
        end
      end
    end
    cs = 8'h00;
    foreach (mdl_q[i]) cs = cs ^ mdl_q[i];
    mdl_q.push_back(cs);
    foreach (mdl_q[i]) exp_q[d].push_back(mdl_q[i]);
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clock) begin
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        exp_q[d].delete();
        exp_busy[d]   = 1'b0;
        exp_done[d]   = 1'b0;
        prev_stall[d] = 1'b0;
      end else begin
        logic acc;
        logic [7:0] e;
        acc = !exp_busy[d] && !exp_done[d];
        chk("valid", d, valid_v[d], exp_busy[d]);
        chk("busy",  d, busy_v[d],  exp_busy[d]);
        chk("done",  d, done_v[d],  exp_done[d]);
        if (prev_stall[d]) begin
          chk("hold valid", d, valid_v[d], 1);
          chk("hold data",  d, data_v[d],  prev_data[d]);
        end
        exp_done[d] = 1'b0;
        if (valid_v[d] && ready[d]) begin
          if (exp_q[d].size() == 0) begin
            chk("unexpected byte", d, data_v[d], 32'hFFFF_FFFF);
          end else begin
            e = exp_q[d].pop_front();
            chk("byte", d, data_v[d], e);
            got_q[d].push_back(data_v[d]);
            if (exp_q[d].size() == 0) begin
              exp_busy[d] = 1'b0;
              exp_done[d] = 1'b1;
            end
          end
        end
        prev_stall[d] = valid_v[d] && !ready[d];
        prev_data[d]  = data_v[d];
        if (start[d] && acc) begin
          build_frame(d);
          exp_busy[d] = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    tick(1);
    start[d] = 1'b0;
  endtask

  // Counts negedges until done_o; frame of L bytes with no stall gives L+1.
  task automatic wait_done(input int d, input int exp_n, input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clock);
      if (done_v[d]) begin n = i; break; end
    end
    chk(name, d, n, exp_n);
  endtask

  task automatic chk_lit(input string name, input int d, input int base);
    chk({name, " model len"}, d, mdl_q.size(), lit_q.size());
    chk({name, " dut len"},   d, got_q[d].size() - base, lit_q.size());
    foreach (lit_q[i]) begin
      if (i < mdl_q.size())
        chk($sformatf("%s model byte%0d", name, i), d, mdl_q[i], lit_q[i]);
      if (base + i < got_q[d].size())
        chk($sformatf("%s dut byte%0d", name, i), d, got_q[d][base + i], lit_q[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    start  = '0;
    ready  = 3'b111;
    mask_a = '0; mask_b = '0; mask_c = '0;
    snap_a = '0; snap_b = '0; snap_c = '0;
    tick(3);
    reset = 1'b0;
    @(negedge clock);
    chk("reset valid", 0, valid_v, 3'b000);
    chk("reset busy",  0, busy_v,  3'b000);
    chk("reset done",  0, done_v,  3'b000);

    // Single channel, no stall
    tick(1);
    mask_a = 4'b0001;
    snap_a = '0;
    snap_a[39:0] = 40'h11_2233_4455;
    base = got_q[0].size();
    pulse_start(0);
    wait_done(0, 9, "t1 cycles");
    lit_q = '{8'hA5, 8'h01, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'hB5};
    chk_lit("t1", 0, base);

    // Empty mask, back-to-back from the IDLE cycle after DONE
    tick(1);
    mask_a = 4'b0000;
    base = got_q[0].size();
    pulse_start(0);
    wait_done(0, 4, "t2 cycles");
    lit_q = '{8'hA5, 8'h00, 8'hA5};
    chk_lit("t2", 0, base);

    // Sparse mask, skipped channels hold decoy data
    tick(1);
    mask_a = 4'b1010;
    snap_a = {40'hF0E0D0C0B0, 40'h5555555555, 40'h0102030405, 40'hAAAAAAAAAA};
    base = got_q[0].size();
    pulse_start(0);
    wait_done(0, 14, "t3 cycles");
    lit_q = '{8'hA5, 8'h0A, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01,
              8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0, 8'h1E};
    chk_lit("t3", 0, base);

    // Backpressure in PAYLOAD while inputs change
    tick(1);
    mask_a = 4'b0101;
    snap_a = {40'h0, 40'hFEDCBA9876, 40'h0, 40'h0123456789};
    base = got_q[0].size();
    pulse_start(0);
    fork
      wait_done(0, 17, "t4 cycles");
      begin
        tick(2);
        ready[0] = 1'b0;
        snap_a   = ~snap_a;
        mask_a   = 4'b1111;
        tick(3);
        ready[0] = 1'b1;
      end
    join
    lit_q = '{8'hA5, 8'h05, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01,
              8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE, 8'h5F};
    chk_lit("t4", 0, base);

    // Start during PAYLOAD and during DONE are both ignored
    tick(1);
    mask_a = 4'b1111;
    snap_a = {40'h1357_9BDF_02, 40'h2468_ACE0_13, 40'h3141_5926_53, 40'h2718_2818_28};
    base = got_q[0].size();
    pulse_start(0);
    tick(4);
    pulse_start(0);
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (done_v[0]) break;
    end
    pulse_start(0);
    tick(8);
    chk("t5 one frame len", 0, got_q[0].size() - base, 23);

    // Reset mid-frame, then a fresh full frame
    mask_a = 4'b1111;
    pulse_start(0);
    tick(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clock);
    chk("t6 reset valid", 0, valid_v[0], 0);
    chk("t6 reset busy",  0, busy_v[0],  0);
    chk("t6 reset done",  0, done_v[0],  0);
    tick(1);
    mask_a = 4'b0001;
    snap_a = '0;
    snap_a[39:0] = 40'h11_2233_4455;
    base = got_q[0].size();
    pulse_start(0);
    wait_done(0, 9, "t6 cycles");
    lit_q = '{8'hA5, 8'h01, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'hB5};
    chk_lit("t6", 0, base);

    // Padding with NB_CH=34
    tick(1);
    mask_b = 2'b01;
    snap_b = {34'h2_AAAA_5555, 34'h3_FFFF_FFFF};
    base = got_q[1].size();
    pulse_start(1);
    wait_done(1, 9, "t7 cycles");
    lit_q = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'hA7};
    chk_lit("t7", 1, base);
    tick(1);
    mask_b = 2'b10;
    snap_b = {34'h1_2345_6789, 34'h3_FFFF_FFFF};
    base = got_q[1].size();
    pulse_start(1);
    wait_done(1, 9, "t7b cycles");
    lit_q = '{8'hA5, 8'h02, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h2E};
    chk_lit("t7b", 1, base);

    // Wide counters: 8 channels of 137 bits (18 bytes each)
    tick(1);
    for (int i = 0; i < NCH_C*NBCH_C; i++) snap_c[i] = 1'($urandom_range(0, 1));
    mask_c = 8'hFF;
    pulse_start(2);
    wait_done(2, 148, "t8 full cycles");
    tick(1);
    mask_c = 8'h81;
    pulse_start(2);
    wait_done(2, 40, "t8 sparse cycles");

    tick(4);
    chk("drained a", 0, exp_q[0].size(), 0);
    chk("drained b", 1, exp_q[1].size(), 0);
    chk("drained c", 2, exp_q[2].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
